i2c_target_regbank: RTL

I2C responder (slave) that answers the bus master inside I2C_top. It samples SCL/SDA on the system clock, decodes START, STOP, address and R/W, and acknowledges its own 7-bit address. Master writes land in a NUM_BYTES-deep byte buffer. Master reads are served from a parallel input array. Four instances with different SLAVE_ADDR values populate the multi-slave bus.

---
 rtl/i2c_pkg.sv | 28 ++
 rtl/i2c_bus_sync.sv | 50 +++++
 rtl/i2c_target_regbank.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// ============================================================================
// Module      : i2c_pkg
// Description : Shared types and bus constants for the I2C target register bank
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ADDR      = 3'd1,
      ST_ADDR_ACK  = 3'd2,
      ST_WR_BYTE   = 3'd3,
      ST_WR_ACK    = 3'd4,
      ST_RD_BYTE   = 3'd5,
      ST_RD_ACK    = 3'd6,
      ST_WAIT_STOP = 3'd7
   } i2c_tgt_state_t;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;
   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/i2c_bus_sync.sv
// ============================================================================
// Module      : i2c_bus_sync
// Description : SCL/SDA synchronisers with edge, START and STOP detection
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_bus_sync (
   input  logic clk,
   input  logic reset,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);

   logic r_scl_meta, r_scl_sync, r_scl_hist;
   logic r_sda_meta, r_sda_sync, r_sda_hist;

   // Reset to the idle-bus level so no spurious edge appears after reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_scl_meta <= 1'b1;
         r_scl_sync <= 1'b1;
         r_scl_hist <= 1'b1;
         r_sda_meta <= 1'b1;
         r_sda_sync <= 1'b1;
         r_sda_hist <= 1'b1;
      end else begin
         r_scl_meta <= scl_i;
         r_scl_sync <= r_scl_meta;
         r_scl_hist <= r_scl_sync;
         r_sda_meta <= sda_i;
         r_sda_sync <= r_sda_meta;
         r_sda_hist <= r_sda_sync;
      end
   end

   assign scl_rise  = r_scl_sync & ~r_scl_hist;
   assign scl_fall  = ~r_scl_sync & r_scl_hist;
   assign start_det = r_scl_sync & r_scl_hist & ~r_sda_sync & r_sda_hist;
   assign stop_det  = r_scl_sync & r_scl_hist & r_sda_sync & ~r_sda_hist;
   assign sda_s     = r_sda_sync;

endmodule

`default_nettype wire

// File: rtl/i2c_target_regbank.sv
// ============================================================================
// Module      : i2c_target_regbank
// Description : I2C target with a write byte buffer and a parallel read bank
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_target_regbank
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = 7'h54,
   parameter int         NUM_BYTES  = 10,
   parameter int         IDXW       = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      scl_i,
   input  logic                      sda_i,
   output logic                      sda_oe,
   input  logic [NUM_BYTES-1:0][7:0] data_in,
   output logic [NUM_BYTES-1:0][7:0] data_out,
   output logic [IDXW-1:0]           rx_count,
   output logic                      busy,
   output logic                      wr_done,
   output logic                      rd_done
);

   logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda;
   logic [7:0] w_byte;

   i2c_tgt_state_t            r_state;
   logic [3:0]                r_bitcnt;
   logic [7:0]                r_shift;
   logic [IDXW-1:0]           r_idx;
   logic [IDXW-1:0]           r_rx_count;
   logic [NUM_BYTES-1:0][7:0] r_data_out;
   logic                      r_rw, r_wr_phase, r_busy, r_sda_oe, r_wr_done, r_rd_done;

   i2c_bus_sync u_sync (
      .clk       (clk),
      .reset     (reset),
      .scl_i     (scl_i),
      .sda_i     (sda_i),
      .scl_rise  (w_scl_rise),
      .scl_fall  (w_scl_fall),
      .start_det (w_start),
      .stop_det  (w_stop),
      .sda_s     (w_sda)
   );

   assign w_byte = {r_shift[6:0], w_sda};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_bitcnt   <= '0;
         r_shift    <= '0;
         r_idx      <= '0;
         r_rx_count <= '0;
         r_data_out <= '0;
         r_rw       <= RW_WRITE;
         r_wr_phase <= 1'b0;
         r_busy     <= 1'b0;
         r_sda_oe   <= 1'b0;
         r_wr_done  <= 1'b0;
         r_rd_done  <= 1'b0;
      end else begin
         r_wr_done <= 1'b0;
         r_rd_done <= 1'b0;
         if (w_stop) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_bitcnt   <= '0;
            r_wr_done  <= r_wr_phase && (r_rx_count != '0);
            r_wr_phase <= 1'b0;
         end else if (w_start) begin
            // busy is left alone here: it follows the next address decision
            r_state    <= ST_ADDR;
            r_sda_oe   <= 1'b0;
            r_bitcnt   <= '0;
            r_idx      <= '0;
            r_wr_done  <= r_wr_phase && (r_rx_count != '0);
            r_wr_phase <= 1'b0;
         end else begin
            case (r_state)
               ST_ADDR: if (w_scl_rise) begin
                  r_shift <= w_byte;
                  if (r_bitcnt == 4'd7) begin
                     r_bitcnt <= '0;
                     if (w_byte[7:1] == SLAVE_ADDR) begin
                        r_state <= ST_ADDR_ACK;
                        r_busy  <= 1'b1;
                        r_rw    <= w_byte[0];
                     end else begin
                        r_state <= ST_WAIT_STOP;
                        r_busy  <= 1'b0;
                     end
                  end else begin
                     r_bitcnt <= r_bitcnt + 4'd1;
                  end
               end
               // First fall drives the ACK, second fall ends the ACK clock
               ST_ADDR_ACK: if (w_scl_fall) begin
                  if (!r_sda_oe) begin
                     r_sda_oe <= ~I2C_ACK;
                  end else if (r_rw == RW_WRITE) begin
                     r_sda_oe   <= 1'b0;
                     r_rx_count <= '0;
                     r_wr_phase <= 1'b1;
                     r_state    <= ST_WR_BYTE;
                  end else begin
                     r_shift  <= data_in[0];
                     r_sda_oe <= ~data_in[0][7];
                     r_bitcnt <= 4'd1;
                     r_state  <= ST_RD_BYTE;
                  end
               end
               ST_WR_BYTE: if (w_scl_rise) begin
                  r_shift <= w_byte;
                  if (r_bitcnt == 4'd7) begin
                     r_bitcnt <= '0;
                     if (r_idx < IDXW'(NUM_BYTES)) begin
                        r_data_out[r_idx] <= w_byte;
                        r_idx             <= r_idx + IDXW'(1);
                        r_rx_count        <= r_rx_count + IDXW'(1);
                        r_state           <= ST_WR_ACK;
                     end else begin
                        r_state <= ST_WAIT_STOP;
                     end
                  end else begin
                     r_bitcnt <= r_bitcnt + 4'd1;
                  end
               end
               ST_WR_ACK: if (w_scl_fall) begin
                  if (!r_sda_oe) begin
                     r_sda_oe <= ~I2C_ACK;
                  end else begin
                     r_sda_oe <= 1'b0;
                     r_state  <= ST_WR_BYTE;
                  end
               end
               // bitcnt 0 marks the first fall of a byte, where data_in is sampled
               ST_RD_BYTE: if (w_scl_fall) begin
                  if (r_bitcnt == 4'd0) begin
                     r_shift  <= data_in[r_idx];
                     r_sda_oe <= ~data_in[r_idx][7];
                     r_bitcnt <= 4'd1;
                  end else if (r_bitcnt == 4'd8) begin
                     r_sda_oe <= 1'b0;
                     r_bitcnt <= '0;
                     r_state  <= ST_RD_ACK;
                  end else begin
                     r_shift  <= {r_shift[6:0], 1'b0};
                     r_sda_oe <= ~r_shift[6];
                     r_bitcnt <= r_bitcnt + 4'd1;
                  end
               end
               ST_RD_ACK: if (w_scl_rise) begin
                  if (w_sda == I2C_ACK) begin
                     r_idx   <= (r_idx == IDXW'(NUM_BYTES - 1)) ? '0 : r_idx + IDXW'(1);
                     r_state <= ST_RD_BYTE;
                  end else begin
                     r_rd_done <= 1'b1;
                     r_state   <= ST_WAIT_STOP;
                  end
               end
               ST_IDLE, ST_WAIT_STOP: begin
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign sda_oe   = r_sda_oe;
   assign data_out = r_data_out;
   assign rx_count = r_rx_count;
   assign busy     = r_busy;
   assign wr_done  = r_wr_done;
   assign rd_done  = r_rd_done;

endmodule

`default_nettype wire
